// File: rtl/qspi_psram_responder.sv
// qspi_psram_responder: SPI/QPI pseudo-SRAM target backed by a 2**ADDR_W byte array
// Ports: clk, rst (sync, active high); ce_n, sck, dio_in[3:0] from the initiator (async to clk);
//        dio_out[3:0]/dio_oe[3:0] drive io3..io0; qpi_mode = QPI command mode; busy = FSM not IDLE.
// Option: define QSPI_PSRAM_RESPONDER_QPI_EN to enable 0x35, 0xF5, 0xEB and 0x38.
module qspi_psram_responder #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYCLES = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce_n,
   input  logic       sck,
   input  logic [3:0] dio_in,
   output logic [3:0] dio_out,
   output logic [3:0] dio_oe,
   output logic       qpi_mode,
   output logic       busy
);
`ifdef QSPI_PSRAM_RESPONDER_QPI_EN
   localparam bit QPI_EN = 1'b1;
`else
   localparam bit QPI_EN = 1'b0;
`endif
   localparam int CW = $clog2(WAIT_CYCLES > 24 ? WAIT_CYCLES : 24);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_t;
   state_t state, state_nx;
   logic [2:0] ce_s, sck_s;
   logic [6:0] cs;
   logic [7:0] nx8, rbyte;
   logic [CW-1:0] cnt;
   logic [2:0] bp;
   logic [ADDR_W-1:0] addr, addr_nx;
   logic op_wr, op_quad, qpi;
   logic rise, fall, ce_rise, ce_fall, wide, cmd_last, addr_last, byte_last, known, we;
   logic [7:0] mem [2**ADDR_W];

   // Synchronizers are deliberately not reset: they keep tracking the pins during
   // reset, so a ce_n held low across reset never looks like a fresh falling edge.
   always_ff @(posedge clk) begin
      ce_s  <= {ce_s[1:0], ce_n};
      sck_s <= {sck_s[1:0], sck};
   end

   assign rise      = sck_s[1] & ~sck_s[2];
   assign fall      = ~sck_s[1] & sck_s[2];
   assign ce_rise   = ce_s[1] & ~ce_s[2];
   assign ce_fall   = ~ce_s[1] & ce_s[2];
   assign wide      = state == WDATA ? op_quad : qpi;
   assign nx8       = wide ? {cs[3:0], dio_in} : {cs, dio_in[0]};
   assign addr_nx   = qpi ? {addr[ADDR_W-5:0], dio_in} : {addr[ADDR_W-2:0], dio_in[0]};
   assign rbyte     = mem[addr];
   assign cmd_last  = cnt == (qpi ? CW'(1) : CW'(7));
   assign addr_last = cnt == (qpi ? CW'(5) : CW'(23));
   assign byte_last = op_quad ? bp[0] : &bp;
   assign known     = nx8 == 8'h03 || nx8 == 8'h02 || (QPI_EN && (nx8 == 8'hEB || nx8 == 8'h38));
   assign we        = !rst && !ce_rise && rise && state == WDATA && byte_last;
   assign busy      = state != IDLE;
   assign qpi_mode  = qpi;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state != IDLE && ce_rise) state_nx = IDLE;
      else if (state == IDLE) state_nx = ce_fall ? CMD : IDLE;
      else if (rise) case (state)
         CMD:     if (cmd_last) state_nx = known ? ADDR : IGNORE;
         ADDR:    if (addr_last) state_nx = op_wr ? WDATA : (op_quad && WAIT_CYCLES != 0) ? WAIT : RDATA;
         WAIT:    if (cnt == CW'(WAIT_CYCLES - 1)) state_nx = RDATA;
         default: state_nx = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cs      <= '0;
         cnt     <= '0;
         bp      <= '0;
         addr    <= '0;
         op_wr   <= 1'b0;
         op_quad <= 1'b0;
         qpi     <= 1'b0;
         dio_out <= '0;
         dio_oe  <= '0;
      end else begin
         // Output enable rises with the first driven bit and drops the cycle the FSM leaves RDATA.
         dio_oe <= state_nx != RDATA ? 4'h0 : (state == RDATA && fall) ? (op_quad ? 4'hF : 4'h2) : dio_oe;
         if (state == IDLE) begin
            cs  <= '0;
            cnt <= '0;
            bp  <= '0;
         end else if (!ce_rise) begin
            if (rise && (state == CMD || state == ADDR || state == WAIT))
               cnt <= (state == CMD && cmd_last) || (state == ADDR && addr_last) ? '0 : cnt + 1'b1;
            if (rise && (state == CMD || state == WDATA)) cs <= nx8[6:0];
            if (rise && state == ADDR) addr <= addr_nx;
            if (rise && state == CMD && cmd_last) begin
               op_wr   <= nx8 == 8'h02 || nx8 == 8'h38;
               op_quad <= QPI_EN && (nx8 == 8'hEB || nx8 == 8'h38);
               if (QPI_EN && nx8 == 8'h35) qpi <= 1'b1;
               if (QPI_EN && nx8 == 8'hF5) qpi <= 1'b0;
            end
            if ((rise && state == WDATA) || (fall && state == RDATA)) begin
               bp <= byte_last ? '0 : bp + 1'b1;
               if (byte_last) addr <= addr + 1'b1;
            end
            if (fall && state == RDATA)
               dio_out <= op_quad ? (bp[0] ? rbyte[3:0] : rbyte[7:4]) : {2'b00, rbyte[3'd7 - bp], 1'b0};
         end
      end
   end

   // Array has no reset so its contents survive rst; only completed bytes are written.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= nx8;
   end
endmodule

// File: tb/tb_qspi_psram_responder.sv
// tb_qspi_psram_responder: directed bench with a byte-array/mode model of the responder
module tb_qspi_psram_responder;
`ifdef QSPI_PSRAM_RESPONDER_QPI_EN
   localparam bit QPI_EN = 1'b1;
`else
   localparam bit QPI_EN = 1'b0;
`endif
   localparam int DEPTH = 4096;
   localparam int WAIT  = 6;
   logic clk = 1'b0;
   logic rst, ce_n, sck;
   logic [3:0] dio_in, dio_out, dio_oe;
   logic qpi_mode, busy;
   logic [7:0] model_mem [DEPTH];
   logic model_qpi = 1'b0;
   logic [7:0] wbuf [8];
   logic [7:0] rbuf [8];
   logic chk_en = 1'b0;
   logic [3:0] exp_oe, exp_out;
   logic exp_busy, exp_qpi;
   int checks = 0;
   int errors = 0;

   qspi_psram_responder #(.ADDR_W(12), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst(rst), .ce_n(ce_n), .sck(sck), .dio_in(dio_in),
      .dio_out(dio_out), .dio_oe(dio_oe), .qpi_mode(qpi_mode), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         cmp("oe", {4'h0, dio_oe}, {4'h0, exp_oe});
         cmp("busy", {7'h0, busy}, {7'h0, exp_busy});
         cmp("qpi", {7'h0, qpi_mode}, {7'h0, exp_qpi});
         if (exp_oe != 4'h0) cmp("dout", {4'h0, dio_out & exp_oe}, {4'h0, exp_out & exp_oe});
      end
   end

   task automatic half();
      repeat (4) @(negedge clk);
   endtask

   task automatic expect_set(input logic [3:0] oe, input logic [3:0] o, input logic b);
      exp_oe = oe;
      exp_out = o;
      exp_busy = b;
      exp_qpi = model_qpi;
      chk_en = 1'b1;
      @(negedge clk);
      chk_en = 1'b0;
   endtask

   task automatic send(input logic [3:0] d);
      dio_in = d;
      repeat (3) @(negedge clk);
      expect_set(4'h0, 4'h0, 1'b1);
      sck = 1'b1;
      half();
      sck = 1'b0;
   endtask

   task automatic send_val(input logic [23:0] v, input int bits, input logic quad);
      for (int i = bits - (quad ? 4 : 1); i >= 0; i -= (quad ? 4 : 1))
         send(quad ? v[i +: 4] : {3'b000, v[i]});
   endtask

   task automatic end_frame();
      ce_n = 1'b1;
      repeat (2) @(negedge clk);
      expect_set(4'h0, 4'h0, 1'b0);
      half();
   endtask

   task automatic frame(input logic [7:0] cmd, input logic [23:0] a, input int nw, input int wpart, input int nrd);
      logic qm, known, quad, rd;
      logic [7:0] b, rb;
      logic [3:0] eo;
      int per, k, j;
      qm = model_qpi;
      known = cmd == 8'h03 || cmd == 8'h02 || (QPI_EN && (cmd == 8'hEB || cmd == 8'h38));
      quad = QPI_EN && (cmd == 8'hEB || cmd == 8'h38);
      rd = cmd == 8'h03 || cmd == 8'hEB;
      per = quad ? 2 : 8;
      rb = 8'h00;
      ce_n = 1'b0;
      half();
      send_val({16'h0, cmd}, 8, qm);
      if (QPI_EN && cmd == 8'h35) model_qpi = 1'b1;
      if (QPI_EN && cmd == 8'hF5) model_qpi = 1'b0;
      if (!known) begin
         for (int i = 0; i < nrd; i++) send(4'hF);
      end else begin
         send_val(a, 24, qm);
         if (rd && quad) for (int i = 0; i < WAIT; i++) send(4'h0);
         if (!rd) begin
            for (int n = 0; n < nw; n++) begin
               send_val({16'h0, wbuf[n]}, 8, quad);
               model_mem[(int'(a) + n) % DEPTH] = wbuf[n];
            end
            for (int i = 0; i < wpart; i++) send(4'hF);
         end else begin
            for (int c = 0; c < nrd; c++) begin
               if (c != 0) begin
                  sck = 1'b1;
                  half();
                  sck = 1'b0;
               end
               k = c / per;
               j = c % per;
               b = model_mem[(int'(a) + k) % DEPTH];
               eo = quad ? (j == 0 ? b[7:4] : b[3:0]) : {2'b00, b[7 - j], 1'b0};
               repeat (3) @(negedge clk);
               rb = quad ? {rb[3:0], dio_out} : {rb[6:0], dio_out[1]};
               if (j == per - 1) rbuf[k] = rb;
               expect_set(quad ? 4'hF : 4'h2, eo, 1'b1);
            end
         end
      end
      end_frame();
   endtask

   task automatic rst_mid();
      logic [7:0] c;
      c = model_qpi ? 8'h38 : 8'h02;
      ce_n = 1'b0;
      half();
      send_val({16'h0, c}, 8, model_qpi);
      send_val(24'h000010, 12, model_qpi);
      rst = 1'b1;
      model_qpi = 1'b0;
      repeat (2) @(negedge clk);
      expect_set(4'h0, 4'h0, 1'b0);
      rst = 1'b0;
      half();
      expect_set(4'h0, 4'h0, 1'b0);
      ce_n = 1'b1;
      half();
      half();
   endtask

   initial begin
      rst = 1'b1;
      ce_n = 1'b1;
      sck = 1'b0;
      dio_in = 4'h0;
      repeat (5) @(negedge clk);
      cmp("rst_oe", {4'h0, dio_oe}, 8'h00);
      cmp("rst_dout", {4'h0, dio_out}, 8'h00);
      cmp("rst_busy", {7'h0, busy}, 8'h00);
      cmp("rst_qpi", {7'h0, qpi_mode}, 8'h00);
      rst = 1'b0;
      half();
      wbuf[0] = 8'hA5;
      wbuf[1] = 8'h5A;
      frame(8'h02, 24'h000010, 2, 0, 0);
      frame(8'h03, 24'h000010, 0, 0, 16);
      cmp("spi_rd0", rbuf[0], 8'hA5);
      cmp("spi_rd1", rbuf[1], 8'h5A);
      frame(8'h03, 24'h000010, 0, 0, 4);
      frame(8'h9F, 24'h000000, 0, 0, 16);
      frame(8'h03, 24'h000011, 0, 0, 8);
      cmp("after_9f", rbuf[0], 8'h5A);
      wbuf[0] = 8'h77;
      wbuf[1] = 8'h88;
      frame(8'h02, 24'h000020, 2, 0, 0);
      wbuf[0] = 8'hC3;
      frame(8'h02, 24'h000020, 1, 4, 0);
      frame(8'h03, 24'h000020, 0, 0, 16);
      cmp("part_wr0", rbuf[0], 8'hC3);
      cmp("part_wr1", rbuf[1], 8'h88);
      wbuf[0] = 8'hDE;
      wbuf[1] = 8'hAD;
      frame(8'h02, 24'h000FFF, 2, 0, 0);
      frame(8'h03, 24'h000FFF, 0, 0, 16);
      cmp("wrap_rd0", rbuf[0], 8'hDE);
      cmp("wrap_rd1", rbuf[1], 8'hAD);
      frame(8'h35, 24'h000000, 0, 0, 0);
      cmp("qpi_after_35", {7'h0, qpi_mode}, {7'h0, QPI_EN});
`ifdef QSPI_PSRAM_RESPONDER_QPI_EN
      wbuf[0] = 8'h11;
      wbuf[1] = 8'h22;
      frame(8'h38, 24'h000FFF, 2, 0, 0);
      frame(8'hEB, 24'h000FFF, 0, 0, 4);
      cmp("quad_rd0", rbuf[0], 8'h11);
      cmp("quad_rd1", rbuf[1], 8'h22);
      frame(8'hF5, 24'h000000, 0, 0, 0);
      cmp("qpi_after_f5", {7'h0, qpi_mode}, 8'h00);
      frame(8'h35, 24'h000000, 0, 0, 0);
`else
      frame(8'h03, 24'h000010, 0, 0, 8);
      cmp("spi_after_35", rbuf[0], 8'hA5);
`endif
      rst_mid();
      cmp("qpi_after_rst", {7'h0, qpi_mode}, 8'h00);
      frame(8'h03, 24'h000010, 0, 0, 16);
      cmp("rst_keep0", rbuf[0], 8'hA5);
      cmp("rst_keep1", rbuf[1], 8'h5A);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
